// File: rtl/miss_wakeup_tracker.sv
// miss_wakeup_tracker
//   Tracks outstanding dcache line misses per cache line. Each miss is
//   answered one cycle later on the rb_* bus with one of two outcomes:
//     rollback+suspend : the strand waits for the line to be filled
//     rollback+retry   : the strand replays the access
//   L2 line requests are sent through a valid/ready port. When a line fill
//   arrives, every strand waiting on that line is woken on resume_strand.
//
// Ports
//   clk, reset           single clock; synchronous active-high reset
//   miss_*               miss report: strand index, line address, vector lane
//   fill_valid/fill_addr L1 line fill completion
//   mem_req_*            line request to L2 (valid/addr out, ready in)
//   rb_*                 registered one-hot rollback / suspend / retry, plus lane
//   resume_strand        registered bitmap of strands woken by a fill

// One pending-miss entry: valid, issued, line address and waiter mask.
// If free and alloc are both asserted, free wins. The top never does this,
// because it only allocates entries that are currently invalid.
module miss_wakeup_entry #(
  parameter int STRANDS         = 4,
  parameter int LINE_ADDR_WIDTH = 26
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       alloc_i,
  input  logic                       waiter_set_i,
  input  logic                       free_i,
  input  logic                       issue_i,
  input  logic [LINE_ADDR_WIDTH-1:0] new_addr_i,
  input  logic [STRANDS-1:0]         new_mask_i,
  input  logic [LINE_ADDR_WIDTH-1:0] miss_addr_i,
  input  logic [LINE_ADDR_WIDTH-1:0] fill_addr_i,
  output logic                       valid_o,
  output logic                       issued_o,
  output logic [LINE_ADDR_WIDTH-1:0] addr_o,
  output logic [STRANDS-1:0]         mask_o,
  output logic                       miss_hit_o,
  output logic                       fill_hit_o
);
  logic                       valid_q,  valid_d;
  logic                       issued_q, issued_d;
  logic [LINE_ADDR_WIDTH-1:0] addr_q,   addr_d;
  logic [STRANDS-1:0]         mask_q,   mask_d;

  always_comb begin
    valid_d  = valid_q;
    issued_d = issued_q;
    addr_d   = addr_q;
    mask_d   = mask_q;
    if (free_i) begin
      valid_d  = 1'b0;
      issued_d = 1'b0;
      mask_d   = '0;
    end else if (alloc_i) begin
      valid_d  = 1'b1;
      issued_d = 1'b0;
      addr_d   = new_addr_i;
      mask_d   = new_mask_i;
    end else begin
      if (waiter_set_i) mask_d   = mask_q | new_mask_i;
      if (issue_i)      issued_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      issued_q <= 1'b0;
      addr_q   <= '0;
      mask_q   <= '0;
    end else begin
      valid_q  <= valid_d;
      issued_q <= issued_d;
      addr_q   <= addr_d;
      mask_q   <= mask_d;
    end
  end

  assign valid_o    = valid_q;
  assign issued_o   = issued_q;
  assign addr_o     = addr_q;
  assign mask_o     = mask_q;
  assign miss_hit_o = valid_q && (addr_q == miss_addr_i);
  assign fill_hit_o = valid_q && (addr_q == fill_addr_i);
endmodule

module miss_wakeup_tracker #(
  parameter int STRANDS         = 4,
  parameter int ENTRIES         = 4,
  parameter int LINE_ADDR_WIDTH = 26
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       miss_valid,
  input  logic [$clog2(STRANDS)-1:0] miss_strand,
  input  logic [LINE_ADDR_WIDTH-1:0] miss_addr,
  input  logic [3:0]                 miss_lane,
  input  logic                       fill_valid,
  input  logic [LINE_ADDR_WIDTH-1:0] fill_addr,
  output logic                       mem_req_valid,
  output logic [LINE_ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                       mem_req_ready,
  output logic [STRANDS-1:0]         rb_rollback_strand,
  output logic [STRANDS-1:0]         rb_suspend_strand,
  output logic [STRANDS-1:0]         rb_retry_strand,
  output logic [3:0]                 rb_rollback_reg_lane,
  output logic [STRANDS-1:0]         resume_strand
);
  localparam int EW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  logic [ENTRIES-1:0]                      ent_valid, ent_issued, ent_miss_hit, ent_fill_hit;
  logic [ENTRIES-1:0][LINE_ADDR_WIDTH-1:0] ent_addr;
  logic [ENTRIES-1:0][STRANDS-1:0]         ent_mask;
  logic [ENTRIES-1:0]                      alloc_vec, waiter_vec, free_vec, issue_vec;

  logic [STRANDS-1:0] strand_bit, all_waiters;
  logic               bypass, any_hit, free_found;
  logic [EW-1:0]      free_idx;

  logic [STRANDS-1:0]         rollback_q, rollback_d, suspend_q, suspend_d;
  logic [STRANDS-1:0]         retry_q, retry_d, resume_q, resume_d;
  logic [3:0]                 lane_q, lane_d;
  logic                       req_valid_q, req_valid_d;
  logic [LINE_ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [EW-1:0]              req_idx_q, req_idx_d;

  // Entry state as it will look after this edge. The L2 request is chosen
  // from this view, so a newly allocated entry is offered in the same cycle
  // its rb_* response appears.
  logic [ENTRIES-1:0]                      valid_nx, issued_nx;
  logic [ENTRIES-1:0][LINE_ADDR_WIDTH-1:0] addr_nx;
  logic                                    req_fire, req_hold;

  for (genvar e = 0; e < ENTRIES; e++) begin : g_ent
    miss_wakeup_entry #(
      .STRANDS        (STRANDS),
      .LINE_ADDR_WIDTH(LINE_ADDR_WIDTH)
    ) u_ent (
      .clk         (clk),
      .reset       (reset),
      .alloc_i     (alloc_vec[e]),
      .waiter_set_i(waiter_vec[e]),
      .free_i      (free_vec[e]),
      .issue_i     (issue_vec[e]),
      .new_addr_i  (miss_addr),
      .new_mask_i  (strand_bit),
      .miss_addr_i (miss_addr),
      .fill_addr_i (fill_addr),
      .valid_o     (ent_valid[e]),
      .issued_o    (ent_issued[e]),
      .addr_o      (ent_addr[e]),
      .mask_o      (ent_mask[e]),
      .miss_hit_o  (ent_miss_hit[e]),
      .fill_hit_o  (ent_fill_hit[e])
    );
  end

  assign strand_bit = STRANDS'(1) << miss_strand;
  assign bypass     = miss_valid && fill_valid && (miss_addr == fill_addr);
  assign any_hit    = |ent_miss_hit;
  assign free_vec   = fill_valid ? ent_fill_hit : '0;
  assign req_fire   = req_valid_q && mem_req_ready;

  always_comb begin
    free_found  = 1'b0;
    free_idx    = '0;
    all_waiters = '0;
    resume_d    = '0;
    issue_vec   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!ent_valid[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = EW'(i);
      end
      if (ent_valid[i]) all_waiters = all_waiters | ent_mask[i];
      if (free_vec[i])  resume_d    = resume_d | ent_mask[i];
    end
    if (req_fire) issue_vec[req_idx_q] = 1'b1;
  end

  // Miss outcome. A fill to the same line in the same cycle takes priority:
  // the data is arriving now, so the strand replays instead of waiting.
  // A miss that matches a pending line joins that entry. Only a miss with
  // no matching line takes a new entry, and only if one is free.
  always_comb begin
    rollback_d = '0;
    suspend_d  = '0;
    retry_d    = '0;
    lane_d     = '0;
    alloc_vec  = '0;
    waiter_vec = '0;
    if (miss_valid) begin
      rollback_d = strand_bit;
      lane_d     = miss_lane;
      if (bypass) begin
        retry_d = strand_bit;
      end else if (any_hit) begin
        waiter_vec = ent_miss_hit;
        suspend_d  = strand_bit;
      end else if (free_found) begin
        alloc_vec[free_idx] = 1'b1;
        suspend_d           = strand_bit;
      end else begin
        retry_d = strand_bit;
      end
    end
  end

  // The offered request stays fixed until it is accepted, even if a
  // lower-index entry is allocated in the meantime. If a fill frees the
  // offered entry, it is dropped and the next candidate is chosen.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      valid_nx[i]  = alloc_vec[i] | (ent_valid[i] & ~free_vec[i]);
      issued_nx[i] = ~alloc_vec[i] & (ent_issued[i] | issue_vec[i]);
      addr_nx[i]   = alloc_vec[i] ? miss_addr : ent_addr[i];
    end
    req_hold    = req_valid_q && !mem_req_ready && !free_vec[req_idx_q];
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    req_idx_d   = req_idx_q;
    if (!req_hold) begin
      req_valid_d = 1'b0;
      req_addr_d  = '0;
      req_idx_d   = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
        if (valid_nx[i] && !issued_nx[i]) begin
          req_valid_d = 1'b1;
          req_addr_d  = addr_nx[i];
          req_idx_d   = EW'(i);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rollback_q  <= '0;
      suspend_q   <= '0;
      retry_q     <= '0;
      lane_q      <= '0;
      resume_q    <= '0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      req_idx_q   <= '0;
    end else begin
      rollback_q  <= rollback_d;
      suspend_q   <= suspend_d;
      retry_q     <= retry_d;
      lane_q      <= lane_d;
      resume_q    <= resume_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      req_idx_q   <= req_idx_d;
    end
  end

  assign rb_rollback_strand   = rollback_q;
  assign rb_suspend_strand    = suspend_q;
  assign rb_retry_strand      = retry_q;
  assign rb_rollback_reg_lane = lane_q;
  assign resume_strand        = resume_q;
  assign mem_req_valid        = req_valid_q;
  assign mem_req_addr         = req_addr_q;

  // A strand that is already waiting on a line is suspended, so it cannot
  // report another miss.
  a_no_dup_waiter: assert property (@(posedge clk) disable iff (reset)
    !(miss_valid && |(all_waiters & strand_bit)));
endmodule

// File: tb/tb_miss_wakeup_tracker.sv
module tb_miss_wakeup_tracker;
  localparam int S  = 8;
  localparam int E  = 4;
  localparam int AW = 26;

  logic          clk = 1'b0;
  logic          reset;
  logic          miss_valid;
  logic [2:0]    miss_strand;
  logic [AW-1:0] miss_addr;
  logic [3:0]    miss_lane;
  logic          fill_valid;
  logic [AW-1:0] fill_addr;
  logic          mem_req_valid;
  logic [AW-1:0] mem_req_addr;
  logic          mem_req_ready;
  logic [S-1:0]  rb_rollback_strand, rb_suspend_strand, rb_retry_strand, resume_strand;
  logic [3:0]    rb_rollback_reg_lane;

  int checks = 0;
  int errors = 0;

  miss_wakeup_tracker #(.STRANDS(S), .ENTRIES(E), .LINE_ADDR_WIDTH(AW)) dut (
    .clk                 (clk),
    .reset               (reset),
    .miss_valid          (miss_valid),
    .miss_strand         (miss_strand),
    .miss_addr           (miss_addr),
    .miss_lane           (miss_lane),
    .fill_valid          (fill_valid),
    .fill_addr           (fill_addr),
    .mem_req_valid       (mem_req_valid),
    .mem_req_addr        (mem_req_addr),
    .mem_req_ready       (mem_req_ready),
    .rb_rollback_strand  (rb_rollback_strand),
    .rb_suspend_strand   (rb_suspend_strand),
    .rb_retry_strand     (rb_retry_strand),
    .rb_rollback_reg_lane(rb_rollback_reg_lane),
    .resume_strand       (resume_strand)
  );

  always #5 clk = ~clk;

  // rb = {rollback, suspend, retry, lane}; mem = {valid, addr}
  wire [3*S+3:0] rb  = {rb_rollback_strand, rb_suspend_strand, rb_retry_strand, rb_rollback_reg_lane};
  wire [AW:0]    mem = {mem_req_valid, mem_req_addr};

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_miss(input logic [2:0] s, input logic [AW-1:0] a, input logic [3:0] l);
    miss_valid = 1'b1; miss_strand = s; miss_addr = a; miss_lane = l;
  endtask

  task automatic drive_idle();
    miss_valid = 1'b0; miss_strand = '0; miss_addr = '0; miss_lane = '0;
    fill_valid = 1'b0; fill_addr = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_req_ready = 1'b0; drive_idle();
    cyc(); cyc();
    reset = 1'b0;
    checks++; if (rb !== '0) begin errors++; $display("FAIL reset_rb got %h exp 0", rb); end
    checks++; if (mem !== '0) begin errors++; $display("FAIL reset_mem got %h exp 0", mem); end
    checks++; if (resume_strand !== '0) begin errors++; $display("FAIL reset_resume got %h exp 0", resume_strand); end
  endtask

  task automatic test_basic();
    drive_miss(3'd1, 26'h100, 4'd7); cyc();
    checks++; if (rb !== {8'h02, 8'h02, 8'h00, 4'h7}) begin errors++; $display("FAIL basic_rb got %h", rb); end
    checks++; if (mem !== {1'b1, 26'h100}) begin errors++; $display("FAIL basic_mem got %h exp %h", mem, {1'b1, 26'h100}); end
    drive_miss(3'd2, 26'h100, 4'd3); cyc();
    checks++; if (rb !== {8'h04, 8'h04, 8'h00, 4'h3}) begin errors++; $display("FAIL merge_rb got %h", rb); end
    checks++; if (mem !== {1'b1, 26'h100}) begin errors++; $display("FAIL merge_mem got %h", mem); end
    drive_idle(); mem_req_ready = 1'b1; cyc();
    mem_req_ready = 1'b0;
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL single_req got %b exp 0", mem_req_valid); end
    checks++; if (rb !== '0) begin errors++; $display("FAIL idle_rb got %h exp 0", rb); end
    fill_valid = 1'b1; fill_addr = 26'h100; cyc();
    checks++; if (resume_strand !== 8'h06) begin errors++; $display("FAIL fill_resume got %h exp 06", resume_strand); end
    drive_idle(); cyc();
    checks++; if (resume_strand !== 8'h00) begin errors++; $display("FAIL resume_clear got %h exp 00", resume_strand); end
  endtask

  task automatic test_bypass();
    drive_miss(3'd0, 26'h200, 4'hF); fill_valid = 1'b1; fill_addr = 26'h200; cyc();
    checks++; if (rb !== {8'h01, 8'h00, 8'h01, 4'hF}) begin errors++; $display("FAIL bypass_rb got %h", rb); end
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL bypass_mem got %b exp 0", mem_req_valid); end
    checks++; if (resume_strand !== 8'h00) begin errors++; $display("FAIL bypass_resume got %h exp 00", resume_strand); end
    drive_idle(); cyc();
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL bypass_noalloc got %b exp 0", mem_req_valid); end
  endtask

  task automatic test_full_and_stall();
    logic [AW-1:0] addrs [4];
    addrs[0] = 26'h10; addrs[1] = 26'h20; addrs[2] = 26'h30; addrs[3] = 26'h40;
    mem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_miss(3'(i), addrs[i], 4'(i + 1)); cyc();
      checks++; if (rb !== {8'(1 << i), 8'(1 << i), 8'h00, 4'(i + 1)}) begin errors++; $display("FAIL fill_table_rb%0d got %h", i, rb); end
      checks++; if (mem !== {1'b1, 26'h10}) begin errors++; $display("FAIL stall_mem%0d got %h", i, mem); end
    end
    drive_miss(3'd4, 26'h50, 4'd5); cyc();
    checks++; if (rb !== {8'h10, 8'h00, 8'h10, 4'h5}) begin errors++; $display("FAIL full_retry_rb got %h", rb); end
    checks++; if (mem !== {1'b1, 26'h10}) begin errors++; $display("FAIL stall_mem4 got %h", mem); end
    drive_idle(); cyc();
    checks++; if (mem !== {1'b1, 26'h10}) begin errors++; $display("FAIL stall_mem5 got %h", mem); end
    mem_req_ready = 1'b1; cyc();
    mem_req_ready = 1'b0;
    checks++; if (mem !== {1'b1, 26'h20}) begin errors++; $display("FAIL next_req got %h exp %h", mem, {1'b1, 26'h20}); end
    fill_valid = 1'b1; fill_addr = 26'h20; cyc();
    checks++; if (resume_strand !== 8'h02) begin errors++; $display("FAIL full_resume got %h exp 02", resume_strand); end
    checks++; if (mem !== {1'b1, 26'h30}) begin errors++; $display("FAIL req_moved got %h exp %h", mem, {1'b1, 26'h30}); end
    drive_idle(); drive_miss(3'd4, 26'h50, 4'd9); cyc();
    checks++; if (rb !== {8'h10, 8'h10, 8'h00, 4'h9}) begin errors++; $display("FAIL realloc_rb got %h", rb); end
    checks++; if (mem !== {1'b1, 26'h30}) begin errors++; $display("FAIL req_stable_alloc got %h", mem); end
    drive_idle(); mem_req_ready = 1'b1; cyc();
    mem_req_ready = 1'b0;
    checks++; if (mem !== {1'b1, 26'h50}) begin errors++; $display("FAIL realloc_req got %h exp %h", mem, {1'b1, 26'h50}); end
  endtask

  task automatic test_reset_mid();
    reset = 1'b1; cyc();
    reset = 1'b0;
    checks++; if (resume_strand !== '0) begin errors++; $display("FAIL mid_reset_resume got %h", resume_strand); end
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_mem got %b", mem_req_valid); end
    checks++; if (rb !== '0) begin errors++; $display("FAIL mid_reset_rb got %h", rb); end
    fill_valid = 1'b1; fill_addr = 26'h40; cyc();
    checks++; if (resume_strand !== '0) begin errors++; $display("FAIL stale_fill40 got %h exp 00", resume_strand); end
    fill_addr = 26'h50; cyc();
    checks++; if (resume_strand !== '0) begin errors++; $display("FAIL stale_fill50 got %h exp 00", resume_strand); end
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL stale_mem got %b exp 0", mem_req_valid); end
    drive_idle(); cyc();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bypass();
    test_full_and_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule

// File: doc/miss_wakeup_tracker.md
MISS_WAKEUP_TRACKER -- requirements
Module: miss_wakeup_tracker

Interface
REQ-001 SHALL have parameter STRANDS, default 4: number of strands tracked; one-hot output width.
REQ-002 SHALL have parameter ENTRIES, default 4: number of pending-miss entries.
REQ-003 SHALL have parameter LINE_ADDR_WIDTH, default 26: cache-line address width.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port miss_valid  input  1  dcache miss reported this cycle.
REQ-007 SHALL have port miss_strand  input  $clog2(STRANDS)  index of the strand that missed.
REQ-008 SHALL have port miss_addr  input  LINE_ADDR_WIDTH  line address of the miss.
REQ-009 SHALL have port miss_lane  input  4  vector lane active at the miss.
REQ-010 SHALL have port fill_valid  input  1  L1 line fill completes this cycle.
REQ-011 SHALL have port fill_addr  input  LINE_ADDR_WIDTH  line address of the fill.
REQ-012 SHALL have port mem_req_valid  output  1  line request to the L2 interface.
REQ-013 SHALL have port mem_req_addr  output  LINE_ADDR_WIDTH  requested line address.
REQ-014 SHALL have port mem_req_ready  input  1  L2 interface accepts the request.
REQ-015 SHALL have port rb_rollback_strand  output  STRANDS  one-hot rollback.
REQ-016 SHALL have port rb_suspend_strand  output  STRANDS  one-hot suspend qualifier.
REQ-017 SHALL have port rb_retry_strand  output  STRANDS  one-hot retry qualifier.
REQ-018 SHALL have port rb_rollback_reg_lane  output  4  restart lane for the strand being rolled back.
REQ-019 SHALL have port resume_strand  output  STRANDS  bitmap of strands woken by a fill.

Function
REQ-020 Each entry SHALL hold: valid, issued, line address, STRANDS-bit waiter mask.
REQ-021 All rb_* and resume_strand outputs SHALL be registered; response appears exactly 1 cycle after the causing input.
REQ-022 Miss whose addr equals fill_addr with fill_valid in the same cycle SHALL produce rollback+retry (suspend=0), lane=miss_lane; no entry is allocated.
REQ-023 Otherwise, miss matching a valid entry's address SHALL set that strand's waiter bit, produce rollback+suspend, lane=miss_lane; no new entry.
REQ-024 Otherwise, with a free entry: allocate the lowest-index free entry (valid=1, issued=0, mask=strand bit) and produce rollback+suspend, lane=miss_lane.
REQ-025 Otherwise (table full, no match): produce rollback+retry, lane=miss_lane; table unchanged.
REQ-026 Encoding SHALL never assert suspend and retry together, nor either without rollback; at most one strand bit SHALL be set in rb_* per cycle.
REQ-027 fill_valid matching a valid entry SHALL assert resume_strand=entry mask next cycle and free the entry (valid=0), whether or not issued.
REQ-028 fill_valid with no matching entry SHALL be ignored (resume_strand=0).
REQ-029 Fill frees the entry in the same edge as a miss allocates; a freed entry SHALL be reusable from the following cycle.
REQ-030 mem_req_valid SHALL assert for the lowest-index entry with valid=1, issued=0; addr and valid SHALL stay stable until mem_req_ready; on valid&&ready the entry's issued=1.
REQ-031 If the requesting entry is freed by a fill before acceptance, mem_req_valid SHALL move to the next candidate or deassert the next cycle.
REQ-032 A miss from a strand already in a waiter mask is illegal; simulation SHALL assert on it.
REQ-033 Address match SHALL compare the full LINE_ADDR_WIDTH bits; entry and waiter masks SHALL never contain X after reset.

Reset
REQ-034 On reset all entries SHALL be invalid, issued=0, masks=0.
REQ-035 On reset rb_rollback_strand, rb_suspend_strand, rb_retry_strand, resume_strand, mem_req_valid SHALL be 0; rb_rollback_reg_lane and mem_req_addr SHALL be 0.
REQ-036 Reset asserted mid-operation SHALL drop all pending misses without emitting resume_strand; outputs 0 the cycle after reset is sampled.

Verification
REQ-037 Miss strand 1, addr 0x100, lane 7 -> next cycle rollback=0010, suspend=0010, retry=0, lane=7; mem_req_valid=1 addr 0x100.
REQ-038 Strand 2 misses 0x100 while pending, then fill 0x100 -> single mem request; resume_strand=0110 one cycle after fill.
REQ-039 Miss 0x200 strand 0 with fill_valid 0x200 same cycle -> rollback=0001, retry=0001, suspend=0; no mem request.
REQ-040 Four distinct misses fill table, fifth strand misses new addr -> retry, not suspend; after one fill, a repeated miss allocates.
REQ-041 Hold mem_req_ready=0 for 5 cycles -> mem_req_valid/addr stable; ready=1 -> next entry presented following cycle.
REQ-042 Reset with 3 pending entries -> no resume_strand, mem_req_valid=0; later fill to those addrs ignored.
